// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU core, mem_arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store accesses onto one fixed-latency memory (IDLE/ISSUE/WAITS/RESP).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_arbiter #(
  parameter int WAIT = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAITS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

  state_t        state_reg, state_next;
  logic          gnt_reg;
  logic [3:0]    cnt_reg;
  logic          mem_we_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;
  logic          both_pick_dm;
  logic          arb_valid;
  logic          arb_dm;
  logic          rd_done;

`ifdef MEM_ARB_RR_EN
  logic last_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_reg <= 1'b1;
    end else if (state_reg == ISSUE) begin
      last_reg <= gnt_reg;
    end
  end

  assign both_pick_dm = ~last_reg;
`else
  assign both_pick_dm = 1'b1;
`endif

  // In RESP only the port that was not just acked may be granted.
  always_comb begin
    arb_valid = 1'b0;
    arb_dm    = 1'b0;
    if (state_reg == IDLE) begin
      arb_valid = bus.if_req | bus.dm_req;
      arb_dm    = (bus.if_req && bus.dm_req) ? both_pick_dm : bus.dm_req;
    end else if (state_reg == RESP) begin
      arb_dm    = ~gnt_reg;
      arb_valid = gnt_reg ? bus.if_req : bus.dm_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_valid) state_next = ISSUE;
      ISSUE:   state_next = WAITS;
      WAITS:   if (cnt_reg == 4'd0) state_next = RESP;
      RESP:    state_next = arb_valid ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en = (state_reg == ISSUE);
    bus.if_ack = (state_reg == RESP) && !gnt_reg;
    bus.dm_ack = (state_reg == RESP) && gnt_reg;
  end

  assign rd_done = (state_reg == WAITS) && (cnt_reg == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_reg       <= 1'b0;
      cnt_reg       <= 4'd0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      if (arb_valid) begin
        gnt_reg      <= arb_dm;
        mem_we_reg   <= arb_dm & bus.dm_we;
        mem_addr_reg <= arb_dm ? bus.dm_addr : bus.if_addr;
        if (arb_dm) begin
          mem_wdata_reg <= bus.dm_wdata;
        end
      end
      if (state_reg == ISSUE) begin
        cnt_reg <= CNT_INIT;
      end else if (state_reg == WAITS && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  // Port 0 = fetch, port 1 = data; stores leave the data read register untouched.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_reg <= '0;
      end else if (rd_done && (gnt_reg == 1'(gi)) && !mem_we_reg) begin
        rdata_reg <= bus.mem_rdata;
      end
    end
  end

  assign bus.if_rdata  = g_port[0].rdata_reg;
  assign bus.dm_rdata  = g_port[1].rdata_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.stall     = (bus.if_req & ~bus.if_ack) | (bus.dm_req & ~bus.dm_ack);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (WAIT = 1, 2, 15) share stimulus, gated by sel.
// Expectations adapt to MEM_ARB_RR_EN for the simultaneous-request cases.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
  localparam bit FIRST_DM = 1'b0;
`else
  localparam bit FIRST_DM = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        if_req_d, dm_req_d, dm_we_d;
  logic [31:0] if_addr_d, dm_addr_d, dm_wdata_d;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) b2 ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) b15 ();

  mem_arbiter #(.WAIT(1),  .AW(AW), .DW(DW)) u1  (.clk(clk), .rst(rst), .bus(b1));
  mem_arbiter #(.WAIT(2),  .AW(AW), .DW(DW)) u2  (.clk(clk), .rst(rst), .bus(b2));
  mem_arbiter #(.WAIT(15), .AW(AW), .DW(DW)) u15 (.clk(clk), .rst(rst), .bus(b15));

  function automatic logic [31:0] rdval(input logic [31:0] a);
    return (a == 32'h10) ? 32'h2008_0005 : (a ^ 32'hC0DE_0000);
  endfunction

  assign b1.if_req  = if_req_d && (sel == 1);
  assign b1.dm_req  = dm_req_d && (sel == 1);
  assign b2.if_req  = if_req_d && (sel == 2);
  assign b2.dm_req  = dm_req_d && (sel == 2);
  assign b15.if_req = if_req_d && (sel == 15);
  assign b15.dm_req = dm_req_d && (sel == 15);
  assign b1.if_addr = if_addr_d;  assign b1.dm_we = dm_we_d;  assign b1.dm_addr = dm_addr_d;  assign b1.dm_wdata = dm_wdata_d;
  assign b2.if_addr = if_addr_d;  assign b2.dm_we = dm_we_d;  assign b2.dm_addr = dm_addr_d;  assign b2.dm_wdata = dm_wdata_d;
  assign b15.if_addr = if_addr_d; assign b15.dm_we = dm_we_d; assign b15.dm_addr = dm_addr_d; assign b15.dm_wdata = dm_wdata_d;

  // Memory models: data is valid only in the cycle WAIT cycles after the strobe, garbage otherwise.
  logic [31:0] la1, la2, la15;
  logic [4:0]  age1, age2, age15;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age1 <= 5'd0; age2 <= 5'd0; age15 <= 5'd0;
      la1 <= 32'd0; la2 <= 32'd0; la15 <= 32'd0;
    end else begin
      if (b1.mem_en) begin la1 <= b1.mem_addr; age1 <= 5'd1; end
      else if (age1 != 5'd0 && age1 != 5'd31) age1 <= age1 + 5'd1;
      if (b2.mem_en) begin la2 <= b2.mem_addr; age2 <= 5'd1; end
      else if (age2 != 5'd0 && age2 != 5'd31) age2 <= age2 + 5'd1;
      if (b15.mem_en) begin la15 <= b15.mem_addr; age15 <= 5'd1; end
      else if (age15 != 5'd0 && age15 != 5'd31) age15 <= age15 + 5'd1;
    end
  end
  assign b1.mem_rdata  = (age1 == 5'd1)   ? rdval(la1)  : 32'hBAD0_BAD0;
  assign b2.mem_rdata  = (age2 == 5'd2)   ? rdval(la2)  : 32'hBAD0_BAD0;
  assign b15.mem_rdata = (age15 == 5'd15) ? rdval(la15) : 32'hBAD0_BAD0;

  logic        o_en, o_we, o_iack, o_dack, o_stall;
  logic [31:0] o_addr, o_wdata, o_ird, o_drd;
  always_comb begin
    o_en = b2.mem_en; o_we = b2.mem_we; o_addr = b2.mem_addr; o_wdata = b2.mem_wdata;
    o_iack = b2.if_ack; o_dack = b2.dm_ack; o_stall = b2.stall; o_ird = b2.if_rdata; o_drd = b2.dm_rdata;
    if (sel == 1) begin
      o_en = b1.mem_en; o_we = b1.mem_we; o_addr = b1.mem_addr; o_wdata = b1.mem_wdata;
      o_iack = b1.if_ack; o_dack = b1.dm_ack; o_stall = b1.stall; o_ird = b1.if_rdata; o_drd = b1.dm_rdata;
    end else if (sel == 15) begin
      o_en = b15.mem_en; o_we = b15.mem_we; o_addr = b15.mem_addr; o_wdata = b15.mem_wdata;
      o_iack = b15.if_ack; o_dack = b15.dm_ack; o_stall = b15.stall; o_ird = b15.if_rdata; o_drd = b15.dm_rdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag, input logic exp_stall);
    chk({tag, " mem_en"}, 32'(o_en), 32'd0);
    chk({tag, " mem_we"}, 32'(o_we), 32'd0);
    chk({tag, " mem_addr"}, o_addr, 32'd0);
    chk({tag, " mem_wdata"}, o_wdata, 32'd0);
    chk({tag, " if_ack"}, 32'(o_iack), 32'd0);
    chk({tag, " dm_ack"}, 32'(o_dack), 32'd0);
    chk({tag, " if_rdata"}, o_ird, 32'd0);
    chk({tag, " dm_rdata"}, o_drd, 32'd0);
    chk({tag, " stall"}, 32'(o_stall), 32'(exp_stall));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          dw;
    logic [31:0] da;
    logic [31:0] dd;
    bit          e_en;
    bit          e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    bit          e_iack;
    bit          e_dack;
    bit          e_stall;
    logic [31:0] e_ird;
    logic [31:0] e_drd;
  } vec_t;

  function automatic vec_t mk(bit ir, logic [31:0] ia, bit dr, bit dw, logic [31:0] da, logic [31:0] dd,
                              bit en, bit we, logic [31:0] addr, logic [31:0] wd,
                              bit iack, bit dack, bit stall, logic [31:0] ird, logic [31:0] drd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.e_en = en; v.e_we = we; v.e_addr = addr; v.e_wdata = wd;
    v.e_iack = iack; v.e_dack = dack; v.e_stall = stall; v.e_ird = ird; v.e_drd = drd;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] a_first, a_second;
    bit          gdm;
    int          k;

    // WAIT=2: single fetch, store, load, then a store issued straight after the load ack.
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0,                    0, 0, 0, 0,                               0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0,                    1, 0, 32'h10, 0,                          0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0,                    0, 0, 0, 0,                               0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0,                    0, 0, 0, 0,                               0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0,                    0, 0, 0, 0,                               1, 0, 0, 32'h2008_0005, 0));
    vecs.push_back(mk(0, 32'h10, 0, 0, 0, 0,                    0, 0, 0, 0,                               0, 0, 0, 32'h2008_0005, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF,       0, 0, 0, 0,                               0, 0, 1, 32'h2008_0005, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF,       1, 1, 32'h200, 32'hDEAD_BEEF,             0, 0, 1, 32'h2008_0005, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF,       0, 0, 0, 0,                               0, 0, 1, 32'h2008_0005, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF,       0, 0, 0, 0,                               0, 0, 1, 32'h2008_0005, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF,       0, 0, 0, 0,                               0, 1, 0, 32'h2008_0005, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                         0, 0, 0, 0,                               0, 0, 0, 32'h2008_0005, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h100, 0,                   0, 0, 0, 0,                               0, 0, 1, 32'h2008_0005, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h100, 0,                   1, 0, 32'h100, 0,                         0, 0, 1, 32'h2008_0005, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h100, 0,                   0, 0, 0, 0,                               0, 0, 1, 32'h2008_0005, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h100, 0,                   0, 0, 0, 0,                               0, 0, 1, 32'h2008_0005, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h100, 0,                   0, 0, 0, 0,                               0, 1, 0, 32'h2008_0005, 32'hC0DE_0100));
    vecs.push_back(mk(0, 0, 1, 1, 32'h204, 32'h1234_5678,       0, 0, 0, 0,                               0, 0, 1, 32'h2008_0005, 32'hC0DE_0100));
    vecs.push_back(mk(0, 0, 1, 1, 32'h204, 32'h1234_5678,       1, 1, 32'h204, 32'h1234_5678,             0, 0, 1, 32'h2008_0005, 32'hC0DE_0100));
    vecs.push_back(mk(0, 0, 1, 1, 32'h204, 32'h1234_5678,       0, 0, 0, 0,                               0, 0, 1, 32'h2008_0005, 32'hC0DE_0100));
    vecs.push_back(mk(0, 0, 1, 1, 32'h204, 32'h1234_5678,       0, 0, 0, 0,                               0, 0, 1, 32'h2008_0005, 32'hC0DE_0100));
    vecs.push_back(mk(0, 0, 1, 1, 32'h204, 32'h1234_5678,       0, 0, 0, 0,                               0, 1, 0, 32'h2008_0005, 32'hC0DE_0100));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                         0, 0, 0, 0,                               0, 0, 0, 32'h2008_0005, 32'hC0DE_0100));

    rst = 1'b1; sel = 2;
    if_req_d = 1'b0; dm_req_d = 1'b0; dm_we_d = 1'b0;
    if_addr_d = 32'd0; dm_addr_d = 32'd0; dm_wdata_d = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset", 1'b0);
    $display("reset values checked");
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      sel = 2;
      if_req_d = vecs[i].ir; if_addr_d = vecs[i].ia;
      dm_req_d = vecs[i].dr; dm_we_d = vecs[i].dw; dm_addr_d = vecs[i].da; dm_wdata_d = vecs[i].dd;
      @(negedge clk);
      chk($sformatf("v%0d mem_en", i), 32'(o_en), 32'(vecs[i].e_en));
      if (vecs[i].e_en) begin
        chk($sformatf("v%0d mem_we", i), 32'(o_we), 32'(vecs[i].e_we));
        chk($sformatf("v%0d mem_addr", i), o_addr, vecs[i].e_addr);
        if (vecs[i].e_we) chk($sformatf("v%0d mem_wdata", i), o_wdata, vecs[i].e_wdata);
      end
      chk($sformatf("v%0d if_ack", i), 32'(o_iack), 32'(vecs[i].e_iack));
      chk($sformatf("v%0d dm_ack", i), 32'(o_dack), 32'(vecs[i].e_dack));
      chk($sformatf("v%0d stall", i), 32'(o_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d if_rdata", i), o_ird, vecs[i].e_ird);
      chk($sformatf("v%0d dm_rdata", i), o_drd, vecs[i].e_drd);
      $display("vec %0d: en=%b addr=%h iack=%b dack=%b stall=%b", i, o_en, o_addr, o_iack, o_dack, o_stall);
      next_cycle();
    end

    // Reset during WAITS of a fetch, then the held request completes with full latency.
    sel = 2; if_req_d = 1'b1; if_addr_d = 32'h10; dm_req_d = 1'b0; dm_we_d = 1'b0;
    @(negedge clk); chk("rst c0 stall", 32'(o_stall), 32'd1); next_cycle();
    @(negedge clk); chk("rst c1 mem_en", 32'(o_en), 32'd1); next_cycle();
    @(negedge clk); chk("rst c2 if_ack", 32'(o_iack), 32'd0);
    rst = 1'b1;
    #1;
    chk_reset_vals("midreset", 1'b1);
    $display("mid-access reset applied");
    next_cycle();
    rst = 1'b0;
    for (int r = 0; r < 6; r++) begin
      if_req_d = (r < 5);
      @(negedge clk);
      chk($sformatf("rr%0d mem_en", r), 32'(o_en), 32'(r == 1));
      chk($sformatf("rr%0d if_ack", r), 32'(o_iack), 32'(r == 4));
      chk($sformatf("rr%0d stall", r), 32'(o_stall), 32'(r < 4));
      if (r == 1) chk("rr1 mem_addr", o_addr, 32'h10);
      if (r == 4) chk("rr4 if_rdata", o_ird, 32'h2008_0005);
      $display("post-reset cycle %0d: en=%b iack=%b", r, o_en, o_iack);
      next_cycle();
    end

    // WAIT=1: fetch and load requested in the same cycle.
    sel = 1; if_addr_d = 32'h4; dm_addr_d = 32'h100; dm_we_d = 1'b0;
    a_first  = FIRST_DM ? 32'h100 : 32'h4;
    a_second = FIRST_DM ? 32'h4 : 32'h100;
    for (int c = 0; c < 8; c++) begin
      if_req_d = FIRST_DM ? (c < 7) : (c < 4);
      dm_req_d = FIRST_DM ? (c < 4) : (c < 7);
      @(negedge clk);
      chk($sformatf("sim c%0d mem_en", c), 32'(o_en), 32'(c == 1 || c == 4));
      if (c == 1) chk("sim c1 mem_addr", o_addr, a_first);
      if (c == 4) chk("sim c4 mem_addr", o_addr, a_second);
      chk($sformatf("sim c%0d dm_ack", c), 32'(o_dack), 32'(FIRST_DM ? (c == 3) : (c == 6)));
      chk($sformatf("sim c%0d if_ack", c), 32'(o_iack), 32'(FIRST_DM ? (c == 6) : (c == 3)));
      chk($sformatf("sim c%0d stall", c), 32'(o_stall), 32'(c < 6));
      if (o_dack) chk("sim dm_rdata", o_drd, 32'hC0DE_0100);
      if (o_iack) chk("sim if_rdata", o_ird, 32'hC0DE_0004);
      $display("simul cycle %0d: en=%b addr=%h iack=%b dack=%b", c, o_en, o_addr, o_iack, o_dack);
      next_cycle();
    end

    // WAIT=1: both ports request continuously; grants must alternate.
    if_addr_d = 32'h40; dm_addr_d = 32'h140; dm_we_d = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if_req_d = (c <= 18);
      dm_req_d = (c <= 18);
      @(negedge clk);
      chk($sformatf("alt c%0d mem_en", c), 32'(o_en), 32'(c >= 1 && c <= 19 && (c - 1) % 3 == 0));
      if (c >= 1 && c <= 19 && (c - 1) % 3 == 0) begin
        k = (c - 1) / 3;
        gdm = FIRST_DM ^ k[0];
        chk($sformatf("alt c%0d mem_addr", c), o_addr, gdm ? 32'h140 : 32'h40);
      end
      if (c >= 3 && c <= 21 && (c - 3) % 3 == 0) begin
        k = (c - 3) / 3;
        gdm = FIRST_DM ^ k[0];
        chk($sformatf("alt c%0d dm_ack", c), 32'(o_dack), 32'(gdm));
        chk($sformatf("alt c%0d if_ack", c), 32'(o_iack), 32'(!gdm));
        if (gdm) chk($sformatf("alt c%0d dm_rdata", c), o_drd, 32'hC0DE_0140);
        else     chk($sformatf("alt c%0d if_rdata", c), o_ird, 32'hC0DE_0040);
      end else begin
        chk($sformatf("alt c%0d no ack", c), 32'({o_iack, o_dack}), 32'd0);
      end
      chk($sformatf("alt c%0d stall", c), 32'(o_stall), 32'(c <= 18));
      $display("alternate cycle %0d: en=%b addr=%h iack=%b dack=%b", c, o_en, o_addr, o_iack, o_dack);
      next_cycle();
    end

    // WAIT=15: single load, ack exactly in cycle 17.
    sel = 15; if_req_d = 1'b0; dm_addr_d = 32'h300; dm_we_d = 1'b0;
    for (int c = 0; c < 19; c++) begin
      dm_req_d = (c <= 17);
      @(negedge clk);
      chk($sformatf("w15 c%0d mem_en", c), 32'(o_en), 32'(c == 1));
      if (c == 1) chk("w15 mem_addr", o_addr, 32'h300);
      chk($sformatf("w15 c%0d dm_ack", c), 32'(o_dack), 32'(c == 17));
      chk($sformatf("w15 c%0d stall", c), 32'(o_stall), 32'(c <= 16));
      if (c == 17) chk("w15 dm_rdata", o_drd, 32'hC0DE_0300);
      $display("wait15 cycle %0d: en=%b dack=%b stall=%b", c, o_en, o_dack, o_stall);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
